dynamics_envelope: RTL and testbench

//  ADSR amplitude envelope for the synthesized note stream. Sits between notes_player and the codec:

---
 rtl/dynamics_envelope.sv | 142 ++++++++++++++
 tb/tb_dynamics_envelope.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dynamics_envelope.sv
// ADSR amplitude envelope: scales 16-bit signed samples by an 8-bit gain that
// follows attack/decay/sustain/release, stepped by the external minibeat tick.
//
// state   | meaning
// IDLE    | no note (duration 0 or after reset), gain 0
// ATTACK  | gain rising toward 255
// DECAY   | gain falling toward SUSTAIN_LEVEL
// SUSTAIN | gain held at SUSTAIN_LEVEL
// RELEASE | gain falling toward 0 until the next retrigger
module dynamics_envelope #(
  parameter int MINIBEATS_PER_BEAT = 16,
  parameter int SUSTAIN_LEVEL      = 192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play_enable,
  input  logic [15:0] sample_in,
  input  logic [5:0]  duration,
  input  logic [1:0]  attack_time_pow,
  input  logic [1:0]  decay_time_pow,
  input  logic [1:0]  release_time_pow,
  input  logic        minibeat,
  input  logic        toggle_dynamics,
  input  logic        sample_ready,
  output logic [15:0] sample_out,
  output logic        dynamic_sample_ready
);

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  gain_q, gain_d;
  logic [9:0]  elapsed_q, elapsed_d;
  logic [5:0]  dur_q, dur_d;
  logic        play_q, play_d;
  logic [15:0] sample_out_q, sample_out_d;
  logic        ready_q, ready_d;

  logic [9:0]  note_len, release_len, remaining;
  logic [7:0]  atk_step, dec_step, rel_step, rel_gain;
  logic [8:0]  atk_sum;
  logic        trigger;
  logic signed [24:0] prod;

  always_comb begin
    note_len    = 10'(32'(duration) * MINIBEATS_PER_BEAT);
    release_len = 10'd4 << release_time_pow;
    remaining   = note_len - elapsed_q;
    atk_step    = 8'd64 >> attack_time_pow;
    dec_step    = 8'd16 >> decay_time_pow;
    rel_step    = 8'd64 >> release_time_pow;
    atk_sum     = {1'b0, gain_q} + {1'b0, atk_step};
    rel_gain    = (gain_q <= rel_step) ? 8'd0 : gain_q - rel_step;
    trigger     = ((duration != dur_q) && (duration != 6'd0)) || !play_q;

    state_d   = state_q;
    gain_d    = gain_q;
    elapsed_d = elapsed_q;
    dur_d     = duration;
    play_d    = play_enable;

    if (play_enable) begin
      if (duration == 6'd0) begin
        state_d   = IDLE;
        gain_d    = 8'd0;
        elapsed_d = 10'd0;
      end else if (trigger) begin
        state_d   = ATTACK;
        gain_d    = 8'd0;
        elapsed_d = 10'd0;
      end else if (minibeat && (state_q != IDLE)) begin
        if (elapsed_q == note_len - 10'd1) begin
          // End of note restarts it, so repeated equal durations retrigger
          state_d   = ATTACK;
          gain_d    = 8'd0;
          elapsed_d = 10'd0;
        end else begin
          elapsed_d = elapsed_q + 10'd1;
          if ((state_q != RELEASE) && (remaining <= release_len)) begin
            state_d = RELEASE;
            gain_d  = rel_gain;
          end else begin
            case (state_q)
              ATTACK: begin
                if (atk_sum >= 9'd255) begin
                  gain_d  = 8'd255;
                  state_d = DECAY;
                end else begin
                  gain_d = atk_sum[7:0];
                end
              end
              DECAY: begin
                if ({1'b0, gain_q} <= 9'(SUSTAIN_LEVEL) + {1'b0, dec_step}) begin
                  gain_d  = 8'(SUSTAIN_LEVEL);
                  state_d = SUSTAIN;
                end else begin
                  gain_d = gain_q - dec_step;
                end
              end
              RELEASE: gain_d = rel_gain;
              default: gain_d = gain_q;
            endcase
          end
        end
      end
    end
  end

  // Product uses the gain held at the start of the cycle
  always_comb begin
    prod         = $signed(sample_in) * $signed({1'b0, gain_q});
    sample_out_d = sample_out_q;
    ready_d      = sample_ready;
    if (sample_ready) begin
      sample_out_d = toggle_dynamics ? 16'(prod >>> 8) : sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gain_q       <= 8'd0;
      elapsed_q    <= 10'd0;
      dur_q        <= 6'd0;
      play_q       <= 1'b0;
      sample_out_q <= 16'd0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      gain_q       <= gain_d;
      elapsed_q    <= elapsed_d;
      dur_q        <= dur_d;
      play_q       <= play_d;
      sample_out_q <= sample_out_d;
      ready_q      <= ready_d;
    end
  end

  assign sample_out           = sample_out_q;
  assign dynamic_sample_ready = ready_q;

endmodule

// File: tb/tb_dynamics_envelope.sv
// Directed bench for dynamics_envelope: envelope shape, sample scaling,
// bypass, retrigger and freeze behaviour against hand-computed values.
module tb_dynamics_envelope;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic [15:0] sample_in;
  logic [5:0]  duration;
  logic [1:0]  attack_time_pow, decay_time_pow, release_time_pow;
  logic        minibeat;
  logic        toggle_dynamics;
  logic        sample_ready;
  logic [15:0] sample_out;
  logic        dynamic_sample_ready;

  int passed = 0;
  int total  = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_ATTACK = 3'd1, S_DECAY = 3'd2,
                         S_SUSTAIN = 3'd3, S_RELEASE = 3'd4;

  dynamics_envelope dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .sample_in            (sample_in),
    .duration             (duration),
    .attack_time_pow      (attack_time_pow),
    .decay_time_pow       (decay_time_pow),
    .release_time_pow     (release_time_pow),
    .minibeat             (minibeat),
    .toggle_dynamics      (toggle_dynamics),
    .sample_ready         (sample_ready),
    .sample_out           (sample_out),
    .dynamic_sample_ready (dynamic_sample_ready)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic mb();
    minibeat = 1'b1;
    step(1);
    minibeat = 1'b0;
    step(2);
  endtask

  task automatic samp(input string tag, input logic [15:0] x, input logic [15:0] exp);
    sample_in    = x;
    sample_ready = 1'b1;
    step(1);
    sample_ready = 1'b0;
    chk({tag, "_rdy"}, 32'(dynamic_sample_ready), 32'd1);
    chk(tag, 32'(sample_out), 32'(exp));
    step(1);
  endtask

  initial begin
    reset = 1'b1; play_enable = 1'b0; sample_in = 16'd0; duration = 6'd0;
    attack_time_pow = 2'd0; decay_time_pow = 2'd0; release_time_pow = 2'd0;
    minibeat = 1'b0; toggle_dynamics = 1'b1; sample_ready = 1'b0;
    step(3);
    chk("rst_out", 32'(sample_out), 32'd0);
    chk("rst_rdy", 32'(dynamic_sample_ready), 32'd0);
    chk("rst_gain", 32'(dut.gain_q), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
    reset = 1'b0;

    // Note start: play rise with duration 4
    play_enable = 1'b1; duration = 6'd4;
    step(1);
    chk("start_state", 32'(dut.state_q), 32'(S_ATTACK));
    chk("start_gain", 32'(dut.gain_q), 32'd0);
    samp("atk0_out", 16'h4000, 16'h0000);
    mb(); samp("atk1_out", 16'h4000, 16'h1000);
    mb(); samp("atk2_out", 16'h4000, 16'h2000);
    mb(); samp("atk3_out", 16'h4000, 16'h3000);
    mb(); samp("atk4_out", 16'h4000, 16'h3FC0);
    chk("atk4_gain", 32'(dut.gain_q), 32'd255);
    chk("atk4_state", 32'(dut.state_q), 32'(S_DECAY));

    // Decay 255 -> 239,223,207 -> clamp 192
    mb(); mb(); mb();
    chk("dec3_gain", 32'(dut.gain_q), 32'd207);
    mb();
    chk("dec4_gain", 32'(dut.gain_q), 32'd192);
    chk("dec4_state", 32'(dut.state_q), 32'(S_SUSTAIN));
    samp("sus_out", 16'h4000, 16'h3000);
    samp("neg_out", 16'hC000, 16'hD000);

    // Bypass: raw sample, single strobe
    toggle_dynamics = 1'b0;
    sample_in = 16'h8001; sample_ready = 1'b1;
    step(1);
    sample_ready = 1'b0;
    chk("byp_rdy", 32'(dynamic_sample_ready), 32'd1);
    chk("byp_out", 32'(sample_out), 32'h8001);
    step(1);
    chk("byp_rdy_clr", 32'(dynamic_sample_ready), 32'd0);
    chk("byp_hold", 32'(sample_out), 32'h8001);
    toggle_dynamics = 1'b1;

    // Sustain through elapsed=60, then release 128,64,0, auto-retrigger
    repeat (52) mb();
    chk("sus_elapsed", 32'(dut.elapsed_q), 32'd60);
    chk("sus_state", 32'(dut.state_q), 32'(S_SUSTAIN));
    mb();
    chk("rel1_state", 32'(dut.state_q), 32'(S_RELEASE));
    chk("rel1_gain", 32'(dut.gain_q), 32'd128);
    mb();
    chk("rel2_gain", 32'(dut.gain_q), 32'd64);
    mb();
    chk("rel3_gain", 32'(dut.gain_q), 32'd0);
    mb();
    chk("retrig_state", 32'(dut.state_q), 32'(S_ATTACK));
    chk("retrig_elapsed", 32'(dut.elapsed_q), 32'd0);
    mb();
    chk("retrig_gain", 32'(dut.gain_q), 32'd64);
    samp("retrig_out", 16'h4000, 16'h1000);

    // Back to sustain, then change duration 4 -> 8
    repeat (7) mb();
    chk("sus2_state", 32'(dut.state_q), 32'(S_SUSTAIN));
    duration = 6'd8;
    step(1);
    chk("dchg_state", 32'(dut.state_q), 32'(S_ATTACK));
    chk("dchg_gain", 32'(dut.gain_q), 32'd0);
    mb(); mb();
    chk("dchg_gain2", 32'(dut.gain_q), 32'd128);

    // Frozen across 5 minibeats
    play_enable = 1'b0;
    repeat (5) mb();
    chk("frz_gain", 32'(dut.gain_q), 32'd128);
    chk("frz_elapsed", 32'(dut.elapsed_q), 32'd2);
    samp("frz_out", 16'h4000, 16'h2000);
    play_enable = 1'b1;
    step(1);
    chk("play_rise_gain", 32'(dut.gain_q), 32'd0);
    chk("play_rise_state", 32'(dut.state_q), 32'(S_ATTACK));

    // All-release note: release_len 32 >= note_len 16
    release_time_pow = 2'd3; duration = 6'd1;
    step(1);
    mb();
    chk("allrel_state", 32'(dut.state_q), 32'(S_RELEASE));
    chk("allrel_gain", 32'(dut.gain_q), 32'd0);

    duration = 6'd0;
    step(1);
    chk("silence_state", 32'(dut.state_q), 32'(S_IDLE));
    mb();
    chk("silence_elapsed", 32'(dut.elapsed_q), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
